// File: rtl/tmr_pkg.sv
// Shared definitions for the TMR fault injector.
//   DATA_LEN_DEFAULT : default width of every data word
//   LANE_*           : encoding of the inj_lane program field
//   inj_state_t      : injection FSM states
//   decode_lane()    : lane code -> 3-bit corrupt mask {C, B, A}
package tmr_pkg;

    localparam int DATA_LEN_DEFAULT = 27;

    localparam logic [1:0] LANE_A  = 2'd0;
    localparam logic [1:0] LANE_B  = 2'd1;
    localparam logic [1:0] LANE_C  = 2'd2;
    localparam logic [1:0] LANE_AB = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACTIVE,
        ST_DONE
    } inj_state_t;

    // Bit 0 = lane A, bit 1 = lane B, bit 2 = lane C.
    function automatic logic [2:0] decode_lane(input logic [1:0] lane);
        logic [2:0] mask;
        case (lane)
            LANE_A:  mask = 3'b001;
            LANE_B:  mask = 3'b010;
            LANE_C:  mask = 3'b100;
            default: mask = 3'b011;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/tmr_injector_if.sv
// Data path bundle of the TMR injector: source handshake, three replicated
// output lanes with their corrupt flags, and sink handshake.
//   slave  : the injector's view (consumes data_in, produces the lanes)
//   master : the environment's view
interface tmr_injector_if
    import tmr_pkg::*;
#(
    parameter int DATA_LEN = DATA_LEN_DEFAULT
);
    logic [DATA_LEN-1:0] data_in;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_LEN-1:0] dataA_out;
    logic [DATA_LEN-1:0] dataB_out;
    logic [DATA_LEN-1:0] dataC_out;
    logic                A_error_ctrl;
    logic                B_error_ctrl;
    logic                C_error_ctrl;
    logic                out_valid;
    logic                out_ready;

    modport slave (
        input  data_in, in_valid, out_ready,
        output in_ready, dataA_out, dataB_out, dataC_out,
               A_error_ctrl, B_error_ctrl, C_error_ctrl, out_valid
    );

    modport master (
        output data_in, in_valid, out_ready,
        input  in_ready, dataA_out, dataB_out, dataC_out,
               A_error_ctrl, B_error_ctrl, C_error_ctrl, out_valid
    );
endinterface

// File: rtl/tmr_inj_ctrl.sv
// Injection program sequencer: IDLE -> WAIT -> ACTIVE -> DONE -> IDLE.
// Delay and length count accepted words, not cycles.
//   clk, reset      : clock, synchronous active-high reset
//   accept          : a word is being accepted this cycle
//   inj_start/lane/delay/len/sticky : program, latched in IDLE
//   lane_mask       : {C, B, A} corrupt mask for the word accepted this cycle
//   busy, done      : program in progress / one-cycle completion pulse
module tmr_inj_ctrl
    import tmr_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       accept,
    input  logic       inj_start,
    input  logic [1:0] inj_lane,
    input  logic [7:0] inj_delay,
    input  logic [7:0] inj_len,
    input  logic       inj_sticky,
    output logic [2:0] lane_mask,
    output logic       busy,
    output logic       done
);
    inj_state_t state, state_nxt;
    logic [7:0] delay_cnt, delay_nxt;
    logic [7:0] len_cnt, len_nxt;
    logic [1:0] lane_q, lane_nxt;
    logic       sticky_q, sticky_nxt;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            delay_cnt <= 8'd0;
            len_cnt   <= 8'd0;
            lane_q    <= LANE_A;
            sticky_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            delay_cnt <= delay_nxt;
            len_cnt   <= len_nxt;
            lane_q    <= lane_nxt;
            sticky_q  <= sticky_nxt;
        end
    end

    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        state_nxt  = state;
        delay_nxt  = delay_cnt;
        len_nxt    = len_cnt;
        lane_nxt   = lane_q;
        sticky_nxt = sticky_q;
        case (state)
            ST_IDLE: begin
                if (inj_start) begin
                    lane_nxt   = inj_lane;
                    sticky_nxt = inj_sticky;
                    delay_nxt  = inj_delay;
                    len_nxt    = inj_len;
                    // A zero-length, non-sticky program still passes through
                    // WAIT so it completes with a single inj_done pulse.
                    if (inj_delay == 8'd0 && (inj_len != 8'd0 || inj_sticky))
                        state_nxt = ST_ACTIVE;
                    else
                        state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (delay_cnt == 8'd0) begin
                    state_nxt = (len_cnt == 8'd0 && !sticky_q) ? ST_DONE : ST_ACTIVE;
                end else if (accept) begin
                    delay_nxt = delay_cnt - 8'd1;
                    // The word accepted on the last delay count stays clean.
                    if (delay_cnt == 8'd1)
                        state_nxt = (len_cnt == 8'd0 && !sticky_q) ? ST_DONE : ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (accept && !sticky_q) begin
                    if (len_cnt != 8'd0)
                        len_nxt = len_cnt - 8'd1;
                    if (len_cnt <= 8'd1)
                        state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign lane_mask = (state == ST_ACTIVE) ? decode_lane(lane_q) : 3'b000;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

endmodule

// File: rtl/tmr_injector.sv
// TMR fault injector: replicates each accepted source word onto lanes A/B/C
// with one register stage and flags selected lanes as corrupt according to
// the injection program.
//   clk, reset : clock, synchronous active-high reset
//   bus        : data path bundle (slave view)
//   inj_*      : injection program inputs, inj_busy / inj_done status
module tmr_injector
    import tmr_pkg::*;
#(
    parameter int DATA_LEN = DATA_LEN_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    tmr_injector_if.slave     bus,
    input  logic              inj_start,
    input  logic [1:0]        inj_lane,
    input  logic [7:0]        inj_delay,
    input  logic [7:0]        inj_len,
    input  logic              inj_sticky,
    output logic              inj_busy,
    output logic              inj_done
);
    logic [DATA_LEN-1:0] word_q;
    logic [2:0]          err_q;
    logic                valid_q;
    logic [2:0]          lane_mask;
    logic                accept;

    // Output register is free when empty or draining this cycle, which lets
    // back-to-back words stream with no bubble.
    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    tmr_inj_ctrl u_ctrl (
        .clk        (clk),
        .reset      (reset),
        .accept     (accept),
        .inj_start  (inj_start),
        .inj_lane   (inj_lane),
        .inj_delay  (inj_delay),
        .inj_len    (inj_len),
        .inj_sticky (inj_sticky),
        .lane_mask  (lane_mask),
        .busy       (inj_busy),
        .done       (inj_done)
    );

    // Flags are captured with the word they qualify and cleared on drain,
    // so they are never set while out_valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q  <= '0;
            err_q   <= 3'b000;
            valid_q <= 1'b0;
        end else if (accept) begin
            word_q  <= bus.data_in;
            err_q   <= lane_mask;
            valid_q <= 1'b1;
        end else if (bus.out_ready) begin
            err_q   <= 3'b000;
            valid_q <= 1'b0;
        end
    end

    assign bus.dataA_out    = word_q;
    assign bus.dataB_out    = word_q;
    assign bus.dataC_out    = word_q;
    assign bus.A_error_ctrl = err_q[0];
    assign bus.B_error_ctrl = err_q[1];
    assign bus.C_error_ctrl = err_q[2];
    assign bus.out_valid    = valid_q;

endmodule

// File: tb/tb_tmr_injector.sv
// Directed bench for tmr_injector: streaming, delayed single-lane injection,
// back-pressure during ACTIVE, zero-length program, sticky dual-lane program,
// reset mid-program and a 255-word delay.
module tb_tmr_injector;
    import tmr_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       inj_start;
    logic [1:0] inj_lane;
    logic [7:0] inj_delay;
    logic [7:0] inj_len;
    logic       inj_sticky;
    logic       inj_busy;
    logic       inj_done;

    int errors = 0;
    int checks = 0;

    tmr_injector_if #(.DATA_LEN(27)) bus ();

    tmr_injector #(.DATA_LEN(27)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .inj_start  (inj_start),
        .inj_lane   (inj_lane),
        .inj_delay  (inj_delay),
        .inj_len    (inj_len),
        .inj_sticky (inj_sticky),
        .inj_busy   (inj_busy),
        .inj_done   (inj_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // err is {C, B, A}
    task automatic check_out(input string tag, input logic [31:0] word,
                             input logic [2:0] err, input logic valid);
        check({tag, "_a"},     32'(bus.dataA_out), word);
        check({tag, "_b"},     32'(bus.dataB_out), word);
        check({tag, "_c"},     32'(bus.dataC_out), word);
        check({tag, "_err"},   32'({bus.C_error_ctrl, bus.B_error_ctrl, bus.A_error_ctrl}), 32'(err));
        check({tag, "_valid"}, 32'(bus.out_valid), 32'(valid));
    endtask

    task automatic arm(input logic [1:0] lane, input logic [7:0] delay,
                       input logic [7:0] len, input logic sticky);
        inj_lane   = lane;
        inj_delay  = delay;
        inj_len    = len;
        inj_sticky = sticky;
        inj_start  = 1'b1;
    endtask

    initial begin
        reset        = 1'b1;
        inj_start    = 1'b0;
        inj_lane     = 2'd0;
        inj_delay    = 8'd0;
        inj_len      = 8'd0;
        inj_sticky   = 1'b0;
        bus.data_in  = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Reset state and first cycle after reset
        check_out("rst", 32'h0, 3'b000, 1'b0);
        check("rst_busy", 32'(inj_busy), 32'h0);
        check("rst_done", 32'(inj_done), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);

        // Plain streaming, no program
        bus.in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.data_in = 27'(i);
            step();
            check_out("stream", 32'(i), 3'b000, 1'b1);
        end
        bus.in_valid = 1'b0;
        step();
        check("stream_drain_valid", 32'(bus.out_valid), 32'h0);

        // Lane B, delay 2, len 1: third accepted word flagged, then done
        arm(LANE_B, 8'd2, 8'd1, 1'b0);
        step();
        inj_start = 1'b0;
        check("b_busy", 32'(inj_busy), 32'h1);
        bus.in_valid = 1'b1;
        bus.data_in = 27'h10; step(); check_out("b_w1", 32'h10, 3'b000, 1'b1);
        check("b_w1_done", 32'(inj_done), 32'h0);
        bus.data_in = 27'h11; step(); check_out("b_w2", 32'h11, 3'b000, 1'b1);
        check("b_w2_done", 32'(inj_done), 32'h0);
        bus.data_in = 27'h12; step(); check_out("b_w3", 32'h12, 3'b010, 1'b1);
        check("b_w3_done", 32'(inj_done), 32'h1);
        bus.in_valid = 1'b0;
        step();
        check("b_after_done", 32'(inj_done), 32'h0);
        check("b_after_busy", 32'(inj_busy), 32'h0);
        check("b_after_valid", 32'(bus.out_valid), 32'h0);

        // Lane A, delay 0, len 2, with 5 cycles of back-pressure
        arm(LANE_A, 8'd0, 8'd2, 1'b0);
        step();
        inj_start = 1'b0;
        check("bp_busy", 32'(inj_busy), 32'h1);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.data_in   = 27'h20;
        step();
        check_out("bp_w1", 32'h20, 3'b001, 1'b1);
        bus.data_in = 27'h21;
        for (int i = 0; i < 5; i++) begin
            step();
            check_out("bp_hold", 32'h20, 3'b001, 1'b1);
            check("bp_hold_in_ready", 32'(bus.in_ready), 32'h0);
            check("bp_hold_done", 32'(inj_done), 32'h0);
        end
        bus.out_ready = 1'b1;
        step();
        check_out("bp_w2", 32'h21, 3'b001, 1'b1);
        check("bp_w2_done", 32'(inj_done), 32'h1);
        bus.in_valid = 1'b0;
        step();
        check("bp_after_done", 32'(inj_done), 32'h0);
        check("bp_after_valid", 32'(bus.out_valid), 32'h0);

        // Delay 0, len 0: nothing flagged, exactly one done pulse
        arm(LANE_A, 8'd0, 8'd0, 1'b0);
        bus.in_valid = 1'b1;
        bus.data_in  = 27'h30;
        step();
        inj_start = 1'b0;
        check_out("z_w0", 32'h30, 3'b000, 1'b1);
        check("z_w0_busy", 32'(inj_busy), 32'h1);
        check("z_w0_done", 32'(inj_done), 32'h0);
        bus.data_in = 27'h31; step(); check_out("z_w1", 32'h31, 3'b000, 1'b1);
        check("z_w1_done", 32'(inj_done), 32'h1);
        bus.data_in = 27'h32; step(); check_out("z_w2", 32'h32, 3'b000, 1'b1);
        check("z_w2_done", 32'(inj_done), 32'h0);
        check("z_w2_busy", 32'(inj_busy), 32'h0);
        bus.data_in = 27'h33; step(); check_out("z_w3", 32'h33, 3'b000, 1'b1);
        check("z_w3_done", 32'(inj_done), 32'h0);
        bus.in_valid = 1'b0;
        step();

        // Sticky A+B from delay 0; a second start is ignored
        arm(LANE_AB, 8'd0, 8'd0, 1'b1);
        step();
        inj_start = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.data_in = 27'(32'h40 + i);
            if (i == 1) arm(LANE_C, 8'd0, 8'd1, 1'b0);
            step();
            inj_start = 1'b0;
            check_out("sticky", 32'h40 + 32'(i), 3'b011, 1'b1);
            check("sticky_done", 32'(inj_done), 32'h0);
            check("sticky_busy", 32'(inj_busy), 32'h1);
        end
        bus.in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("sticky_rst_busy", 32'(inj_busy), 32'h0);

        // Reset while waiting out a 200-word delay, with a held word
        arm(LANE_C, 8'd200, 8'd1, 1'b0);
        step();
        inj_start = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.data_in   = 27'h50;
        step();
        check_out("wr_held", 32'h50, 3'b000, 1'b1);
        check("wr_busy", 32'(inj_busy), 32'h1);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_out("wr_rst", 32'h0, 3'b000, 1'b0);
        check("wr_rst_busy", 32'(inj_busy), 32'h0);
        check("wr_rst_done", 32'(inj_done), 32'h0);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.data_in = 27'(32'h60 + i);
            step();
            check_out("wr_clean", 32'h60 + 32'(i), 3'b000, 1'b1);
            check("wr_clean_done", 32'(inj_done), 32'h0);
            check("wr_clean_busy", 32'(inj_busy), 32'h0);
        end
        bus.in_valid = 1'b0;
        step();

        // Delay 255 honoured exactly: 255 clean words, then lane C flagged
        arm(LANE_C, 8'd255, 8'd1, 1'b0);
        step();
        inj_start = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 255; i++) begin
            bus.data_in = 27'(i);
            step();
            check("d255_clean_err",
                  32'({bus.C_error_ctrl, bus.B_error_ctrl, bus.A_error_ctrl}), 32'h0);
        end
        bus.data_in = 27'h1FF;
        step();
        check_out("d255_hit", 32'h1FF, 3'b100, 1'b1);
        check("d255_done", 32'(inj_done), 32'h1);
        bus.in_valid = 1'b0;
        step();
        check("d255_after_done", 32'(inj_done), 32'h0);
        check("d255_after_busy", 32'(inj_busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
